// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial sequence detector.
//
// Shifts valid serial bits into a WIDTH-bit window (newest bit in the LSB) and
// compares it against a runtime-loadable pattern (MSB = first bit received).
// A match is only accepted once WIDTH real bits have been collected since the
// last restart, so reset contents of the window can never produce a hit.
// Matches may overlap or, with overlap_en low, restart collection from empty.
//
// Optional feature macro: SEQ_DETECT_CNT_EN
//   defined   - match_cnt counts matches, saturating; cnt_clr clears it and
//               wins over a simultaneous increment.
//   undefined - match_cnt is tied to zero and cnt_clr is ignored.
//
// Ports:
//   p_clk_in    clock, rising edge
//   p_rst       synchronous active-high reset
//   din         serial data bit
//   din_en      din is valid this cycle
//   overlap_en  1 = overlapping matches, 0 = restart after each match
//   pat_we      load pat_in into the pattern register (discards din)
//   pat_in      new pattern, MSB first
//   cnt_clr     clear match counter
//   flag        registered one-cycle match pulse
//   armed       registered, high while WIDTH valid bits are held
//   match_cnt   saturating match count

module seq_detect_param #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1101,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             p_clk_in,
    input  logic             p_rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             overlap_en,
    input  logic             pat_we,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             flag,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned    FW       = $clog2(WIDTH + 1);
    localparam logic [FW-1:0]  FillFull = FW'(WIDTH);

    // Fill level viewed as a state machine; kept in step with fill_q.
    typedef enum logic [1:0] {
        StEmpty,
        StFilling,
        StArmed
    } state_e;

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [FW-1:0]    fill_q, fill_d;
    state_e           state_q, state_d;
    logic             flag_q, flag_d;

    logic [WIDTH-1:0] sh_n;
    logic [FW-1:0]    fill_n;
    logic             match;

    // Candidate window and fill level if the current bit is accepted.
    always_comb begin
        sh_n   = {sh_q[WIDTH-2:0], din};
        fill_n = (fill_q == FillFull) ? FillFull : fill_q + FW'(1);
        match  = din_en && !pat_we && (fill_n == FillFull) && (sh_n == pat_q);
    end

    always_comb begin
        sh_d   = sh_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        flag_d = 1'b0;

        if (pat_we) begin
            // New pattern restarts collection; the bit offered this cycle is dropped.
            pat_d  = pat_in;
            fill_d = '0;
        end else if (din_en) begin
            sh_d   = sh_n;
            flag_d = match;
            fill_d = (match && !overlap_en) ? '0 : fill_n;
        end

        if (fill_d == '0) begin
            state_d = StEmpty;
        end else if (fill_d == FillFull) begin
            state_d = StArmed;
        end else begin
            state_d = StFilling;
        end
    end

    always_ff @(posedge p_clk_in) begin
        if (p_rst) begin
            sh_q    <= '0;
            pat_q   <= PATTERN;
            fill_q  <= '0;
            state_q <= StEmpty;
            flag_q  <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            flag_q  <= flag_d;
        end
    end

    assign flag  = flag_q;
    assign armed = (state_q == StArmed);

    // The oldest window bit only ever shifts out.
    logic unused_sh_msb;
    assign unused_sh_msb = sh_q[WIDTH-1];

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge p_clk_in) begin
        if (p_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;

    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param (WIDTH=4, PATTERN=1101, CNT_W=2).
// Each stimulus cycle pushes the expected post-edge {flag, armed, match_cnt};
// an independent monitor pops and compares after every rising edge.

module tb_seq_detect_param;

`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic       flag;
        logic       armed;
        logic [1:0] cnt;
        int         id;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_en;
    logic       overlap_en;
    logic       pat_we;
    logic [3:0] pat_in;
    logic       cnt_clr;
    logic       flag;
    logic       armed;
    logic [1:0] match_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    seq_detect_param #(
        .WIDTH  (4),
        .PATTERN(4'b1101),
        .CNT_W  (2)
    ) dut (
        .p_clk_in  (clk),
        .p_rst     (rst),
        .din       (din),
        .din_en    (din_en),
        .overlap_en(overlap_en),
        .pat_we    (pat_we),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .flag      (flag),
        .armed     (armed),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle and queue the outputs expected after its rising edge.
    task automatic sb(input logic r, input logic we, input logic en, input logic d,
                      input logic clr, input logic ef, input logic ea, input int ec);
        exp_t e;
        rst     = r;
        pat_we  = we;
        din_en  = en;
        din     = d;
        cnt_clr = clr;
        e.flag  = ef;
        e.armed = ea;
        e.cnt   = CNT_ON ? 2'(ec) : 2'd0;
        e.id    = step_id;
        q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic bitv(input logic d, input logic ef, input logic ea, input int ec);
        sb(1'b0, 1'b0, 1'b1, d, 1'b0, ef, ea, ec);
    endtask

    task automatic gapv(input logic ef, input logic ea, input int ec);
        sb(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ef, ea, ec);
    endtask

    task automatic do_reset();
        sb(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: outputs are sampled 2 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (flag !== e.flag || armed !== e.armed || match_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL step%0d flag/armed/cnt: got %b/%b/%0d want %b/%b/%0d",
                             e.id, flag, armed, match_cnt, e.flag, e.armed, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [0:10] t2_bits;
        logic [0:10] t2_flag;
        logic [0:10] t2_arm;
        int          t2_cnt[11];

        rst        = 1'b1;
        din        = 1'b0;
        din_en     = 1'b0;
        overlap_en = 1'b1;
        pat_we     = 1'b0;
        pat_in     = 4'b0000;
        cnt_clr    = 1'b0;

        // Reset state
        do_reset();

        // Overlapping detection: 1101101 -> pulses after bits 4 and 7
        overlap_en = 1'b1;
        bitv(1'b1, 1'b0, 1'b0, 0);
        bitv(1'b1, 1'b0, 1'b0, 0);
        bitv(1'b0, 1'b0, 1'b0, 0);
        bitv(1'b1, 1'b1, 1'b1, 1);
        bitv(1'b1, 1'b0, 1'b1, 1);
        bitv(1'b0, 1'b0, 1'b1, 1);
        bitv(1'b1, 1'b1, 1'b1, 2);
        sb(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);

        // Non-overlapping: match restarts fill; bit 7 cannot hit, bit 11 does
        do_reset();
        overlap_en = 1'b0;
        t2_bits = 11'b1101101_1101;
        t2_flag = 11'b0001000_0001;
        t2_arm  = 11'b0000000_1110;
        t2_cnt  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2};
        for (int i = 0; i < 11; i++) begin
            bitv(t2_bits[i], t2_flag[i], t2_arm[i], t2_cnt[i]);
        end

        // Gaps of din_en=0 do not break a partial sequence
        do_reset();
        overlap_en = 1'b1;
        bitv(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) gapv(1'b0, 1'b0, 0);
        bitv(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) gapv(1'b0, 1'b0, 0);
        bitv(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) gapv(1'b0, 1'b0, 0);
        bitv(1'b1, 1'b1, 1'b1, 1);
        gapv(1'b0, 1'b1, 1);

        // Pattern load discards the same-cycle bit and restarts fill
        do_reset();
        bitv(1'b1, 1'b0, 1'b0, 0);
        bitv(1'b1, 1'b0, 1'b0, 0);
        pat_in = 4'b0000;
        sb(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) bitv(1'b0, 1'b0, 1'b0, 0);
        bitv(1'b0, 1'b1, 1'b1, 1);
        bitv(1'b1, 1'b0, 1'b1, 1);
        bitv(1'b1, 1'b0, 1'b1, 1);
        bitv(1'b0, 1'b0, 1'b1, 1);
        bitv(1'b1, 1'b0, 1'b1, 1);

        // Reset mid-sequence beats pat_we and restores PATTERN
        bitv(1'b1, 1'b0, 1'b1, 1);
        bitv(1'b1, 1'b0, 1'b1, 1);
        bitv(1'b0, 1'b0, 1'b1, 1);
        pat_in = 4'b0000;
        sb(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        bitv(1'b1, 1'b0, 1'b0, 0);
        bitv(1'b1, 1'b0, 1'b0, 0);
        bitv(1'b0, 1'b0, 1'b0, 0);
        bitv(1'b1, 1'b1, 1'b1, 1);

        // Counter saturation at 3, then clear wins over a simultaneous match
        sb(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        for (int k = 1; k <= 5; k++) begin
            bitv(1'b1, 1'b0, 1'b1, (k - 1 > 3) ? 3 : k - 1);
            bitv(1'b0, 1'b0, 1'b1, (k - 1 > 3) ? 3 : k - 1);
            bitv(1'b1, 1'b1, 1'b1, (k > 3) ? 3 : k);
        end
        bitv(1'b1, 1'b0, 1'b1, 3);
        bitv(1'b0, 1'b0, 1'b1, 3);
        sb(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        gapv(1'b0, 1'b1, 0);

        // Every queued expectation must have been consumed
        #5;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
